// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the frog game: sequences idle, play, death pause,
// level-up pause and game over, and owns lives, level and frog-respawn pulses.
module game_flow_ctrl #(
  parameter int unsigned START_LIVES  = 3,
  parameter logic [4:0]  MAX_LEVEL    = 5'd30,
  parameter logic [23:0] DEATH_HOLD   = 24'd12500000,
  parameter logic [23:0] LEVELUP_HOLD = 24'd6250000,
  parameter int unsigned FLASH_BIT    = 21
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [3:0] i_Switches,
  input  logic       i_Collision,
  input  logic       i_Frog_At_Top,
  output logic [1:0] o_Lives,
  output logic [4:0] o_Level,
  output logic       o_Reset_Frog,
  output logic       o_Freeze,
  output logic       o_Flash,
  output logic       o_Game_Over,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DEATH     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] START_L = 2'(START_LIVES);

  state_t      state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [4:0]  level_q, level_d;
  logic [23:0] timer_q, timer_d;
  logic        reset_frog_q, reset_frog_d;
  logic        freeze_q, freeze_d;
  logic        flash_q, flash_d;
  logic        game_over_q, game_over_d;
  logic [3:0]  sw_prev_q, sw_prev_d;
  logic        coll_prev_q, coll_prev_d;
  logic        top_prev_q, top_prev_d;

  logic combo;
  logic sw_rise;
  logic coll_rise;
  logic top_rise;
  logic pulse_req;

  assign combo     = (i_Switches == 4'hF);
  assign sw_rise   = |(i_Switches & ~sw_prev_q);
  assign coll_rise = i_Collision & ~coll_prev_q;
  assign top_rise  = i_Frog_At_Top & ~top_prev_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    timer_d     = '0;
    pulse_req   = 1'b0;
    sw_prev_d   = i_Switches;
    coll_prev_d = i_Collision;
    top_prev_d  = i_Frog_At_Top;

    if (combo) begin
      state_d   = S_IDLE;
      lives_d   = START_L;
      level_d   = 5'd1;
      pulse_req = (state_q != S_IDLE);
    end else begin
      case (state_q)
        S_IDLE: begin
          lives_d = START_L;
          level_d = 5'd1;
          if (sw_rise) begin
            state_d   = S_PLAY;
            pulse_req = 1'b1;
          end
        end
        S_PLAY: begin
          // Collision takes precedence over reaching the goal row
          if (coll_rise) begin
            if (lives_q <= 2'd1) begin
              state_d = S_GAME_OVER;
              lives_d = 2'd0;
            end else begin
              state_d = S_DEATH;
              lives_d = lives_q - 2'd1;
            end
          end else if (top_rise) begin
            state_d = S_LEVEL_UP;
            level_d = (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + 5'd1;
          end
        end
        S_DEATH: begin
          if (timer_q == DEATH_HOLD - 24'd1) begin
            state_d   = S_PLAY;
            pulse_req = 1'b1;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        S_LEVEL_UP: begin
          if (timer_q == LEVELUP_HOLD - 24'd1) begin
            state_d   = S_PLAY;
            pulse_req = 1'b1;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        S_GAME_OVER: lives_d = 2'd0;
        default:     state_d = S_IDLE;
      endcase
    end

    // Status outputs are derived from the next state so they stay aligned with o_State
    reset_frog_d = pulse_req & ~reset_frog_q;
    freeze_d     = (state_d != S_PLAY);
    flash_d      = (state_d == S_DEATH) & timer_d[FLASH_BIT];
    game_over_d  = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_IDLE;
      lives_q      <= START_L;
      level_q      <= 5'd1;
      timer_q      <= '0;
      reset_frog_q <= 1'b0;
      freeze_q     <= 1'b1;
      flash_q      <= 1'b0;
      game_over_q  <= 1'b0;
      sw_prev_q    <= '0;
      coll_prev_q  <= 1'b0;
      top_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      timer_q      <= timer_d;
      reset_frog_q <= reset_frog_d;
      freeze_q     <= freeze_d;
      flash_q      <= flash_d;
      game_over_q  <= game_over_d;
      sw_prev_q    <= sw_prev_d;
      coll_prev_q  <= coll_prev_d;
      top_prev_q   <= top_prev_d;
    end
  end

  assign o_State      = state_q;
  assign o_Lives      = lives_q;
  assign o_Level      = level_q;
  assign o_Reset_Frog = reset_frog_q;
  assign o_Freeze     = freeze_q;
  assign o_Flash      = flash_q;
  assign o_Game_Over  = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: expected outputs are queued as each
// stimulus cycle is driven and compared once the DUT has clocked it in.
module tb_game_flow_ctrl;

  localparam int DH = 8;
  localparam int LH = 4;
  localparam int FB = 1;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] lives;
    logic [4:0] level;
    logic       rf;
    logic       freeze;
    logic       flash;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] sw;
  logic       coll;
  logic       top;
  logic [1:0] oLives;
  logic [4:0] oLevel;
  logic       oResetFrog;
  logic       oFreeze;
  logic       oFlash;
  logic       oGameOver;
  logic [2:0] oState;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";
  exp_t  expQ[$];

  game_flow_ctrl #(
    .START_LIVES (3),
    .MAX_LEVEL   (5'd30),
    .DEATH_HOLD  (24'd8),
    .LEVELUP_HOLD(24'd4),
    .FLASH_BIT   (1)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rstN),
    .i_Switches   (sw),
    .i_Collision  (coll),
    .i_Frog_At_Top(top),
    .o_Lives      (oLives),
    .o_Level      (oLevel),
    .o_Reset_Frog (oResetFrog),
    .o_Freeze     (oFreeze),
    .o_Flash      (oFlash),
    .o_Game_Over  (oGameOver),
    .o_State      (oState)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [1:0] lv, input logic [4:0] lvl,
                              input logic rf, input logic fz, input logic fl, input logic go);
    exp_t e;
    e.state  = st;
    e.lives  = lv;
    e.level  = lvl;
    e.rf     = rf;
    e.freeze = fz;
    e.flash  = fl;
    e.go     = go;
    return e;
  endfunction

  // Single comparison point: counts every check and reports any disagreement
  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %0d expected %0d", phase, tag, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now
  task automatic compareHead();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("queue_empty", 8'd1, 8'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("state",      {5'd0, oState},     {5'd0, e.state});
      checkOutput("lives",      {6'd0, oLives},     {6'd0, e.lives});
      checkOutput("level",      {3'd0, oLevel},     {3'd0, e.level});
      checkOutput("reset_frog", {7'd0, oResetFrog}, {7'd0, e.rf});
      checkOutput("freeze",     {7'd0, oFreeze},    {7'd0, e.freeze});
      checkOutput("flash",      {7'd0, oFlash},     {7'd0, e.flash});
      checkOutput("game_over",  {7'd0, oGameOver},  {7'd0, e.go});
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check
  task automatic applyStimulus(input logic [3:0] s, input logic c, input logic t, input exp_t e);
    @(negedge clk);
    sw   = s;
    coll = c;
    top  = t;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    compareHead();
  endtask

  // Remainder of a death pause after the entry cycle, ending with the respawn
  task automatic deathRest(input logic [3:0] s, input logic c, input logic t,
                           input logic [1:0] lv, input logic [4:0] lvl);
    for (int i = 1; i < DH; i++)
      applyStimulus(s, c, t, mk(3'd2, lv, lvl, 1'b0, 1'b1, 1'((i >> FB) & 1), 1'b0));
    applyStimulus(s, c, t, mk(3'd1, lv, lvl, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    logic [4:0] lvl;

    rstN = 1'b0;
    sw   = 4'h0;
    coll = 1'b0;
    top  = 1'b0;
    #12;
    phase = "reset";
    expQ.push_back(mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    compareHead();
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));

    phase = "start";
    applyStimulus(4'h1, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(4'h1, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    phase = "death1";
    applyStimulus(4'h0, 1'b1, 1'b0, mk(3'd2, 2'd2, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    deathRest(4'h0, 1'b1, 1'b0, 2'd2, 5'd1);
    applyStimulus(4'h0, 1'b1, 1'b0, mk(3'd1, 2'd2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd1, 2'd2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    phase = "death2";
    applyStimulus(4'h0, 1'b1, 1'b0, mk(3'd2, 2'd1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    deathRest(4'h0, 1'b1, 1'b0, 2'd1, 5'd1);
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd1, 2'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    phase = "gameover";
    applyStimulus(4'h0, 1'b1, 1'b0, mk(3'd4, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd4, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(4'h1, 1'b1, 1'b1, mk(3'd4, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd4, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(4'h8, 1'b0, 1'b0, mk(3'd4, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(4'hF, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    applyStimulus(4'hF, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));

    phase = "levelup";
    applyStimulus(4'h2, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    lvl = 5'd1;
    for (int k = 0; k < 31; k++) begin
      if (lvl < 5'd30) lvl = lvl + 5'd1;
      applyStimulus(4'h0, 1'b0, 1'b1, mk(3'd3, 2'd3, lvl, 1'b0, 1'b1, 1'b0, 1'b0));
      for (int i = 1; i < LH; i++)
        applyStimulus(4'h0, 1'b0, 1'b1, mk(3'd3, 2'd3, lvl, 1'b0, 1'b1, 1'b0, 1'b0));
      applyStimulus(4'h0, 1'b0, 1'b1, mk(3'd1, 2'd3, lvl, 1'b1, 1'b0, 1'b0, 1'b0));
      applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd1, 2'd3, lvl, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    phase = "both_edges";
    applyStimulus(4'h0, 1'b1, 1'b1, mk(3'd2, 2'd2, 5'd30, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i <= 5; i++)
      applyStimulus(4'h0, 1'b1, 1'b1, mk(3'd2, 2'd2, 5'd30, 1'b0, 1'b1, 1'((i >> FB) & 1), 1'b0));

    phase = "mid_reset";
    @(negedge clk);
    rstN = 1'b0;
    #1;
    expQ.push_back(mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    compareHead();
    @(posedge clk);
    #1;
    expQ.push_back(mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    compareHead();
    @(negedge clk);
    sw   = 4'h0;
    coll = 1'b0;
    top  = 1'b0;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    applyStimulus(4'h4, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd1, 2'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    phase = "combo_play";
    applyStimulus(4'hF, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    applyStimulus(4'h0, 1'b0, 1'b0, mk(3'd0, 2'd3, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Central game-flow state machine for the frog game, sitting between frog_display/Shared_Debounce and the level, car and VGA consumers.
- Consumes debounced buttons plus the collision and frog-at-top flags, and owns lives, level, frog-reset pulses and freeze/flash status.
- Replaces the ad-hoc reset_level/lives wiring with one sequenced controller: idle, play, death pause, level-up pause, game over.

Parameters:
START_LIVES, 3, lives loaded at reset and on entering IDLE (1..3)
MAX_LEVEL, 5'd30, level saturation value
DEATH_HOLD, 24'd12500000, cycles spent in DEATH before respawn
LEVELUP_HOLD, 24'd6250000, cycles spent in LEVEL_UP before respawn
FLASH_BIT, 21, timer bit driving o_Flash during DEATH

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Switches  in  4  debounced switches {sw4,sw3,sw2,sw1}
i_Collision  in  1  level, high while frog overlaps a car
i_Frog_At_Top  in  1  level, high while frog occupies goal row
o_Lives  out  2  remaining lives
o_Level  out  5  current level, 1..MAX_LEVEL
o_Reset_Frog  out  1  one-cycle pulse: return frog to start
o_Freeze  out  1  high = frog input and car motion halted
o_Flash  out  1  blink enable for VGA during DEATH
o_Game_Over  out  1  high in GAME_OVER
o_State  out  3  encoded state (IDLE=0, PLAY=1, DEATH=2, LEVEL_UP=3, GAME_OVER=4)

Behaviour:
- Reset (async, i_Rst_n=0) values: state IDLE, o_Lives=START_LIVES, o_Level=1, o_Reset_Frog=0, o_Freeze=1, o_Flash=0, o_Game_Over=0, timer=0, all edge-detect registers=0.
- Edge detection: registered copies of i_Switches, i_Collision and i_Frog_At_Top. An event is a rising edge (current=1, previous=0). A level held across a state change never retriggers.
- Restart combo: i_Switches==4'hF in any state → IDLE next cycle. This has highest priority.
- Outputs are registered. Each transition becomes visible on o_State one cycle after the triggering edge.
- IDLE: o_Freeze=1, lives=START_LIVES, level=1. Any switch rising edge with combo not active → PLAY, o_Reset_Frog pulses 1 cycle coincident with entering PLAY.
- PLAY: o_Freeze=0.
  - Collision edge → decrement lives. If lives was 1 → GAME_OVER with o_Lives=0; else → DEATH, timer cleared.
  - Frog-at-top edge → LEVEL_UP; level increments on entry, saturating at MAX_LEVEL (no wrap), timer cleared.
  - Collision and frog-at-top edges in the same cycle: collision wins, level unchanged.
- DEATH: o_Freeze=1, o_Flash=timer[FLASH_BIT]. Timer increments each cycle. When timer==DEATH_HOLD-1 → PLAY with o_Reset_Frog pulse. Collision/top edges are ignored.
- LEVEL_UP: o_Freeze=1, o_Flash=0. When timer==LEVELUP_HOLD-1 → PLAY with o_Reset_Frog pulse. Edges are ignored.
- GAME_OVER: o_Freeze=1, o_Game_Over=1, o_Lives=0, o_Level holds its final value. Exit only via the restart combo or reset.
- o_Reset_Frog also pulses 1 cycle on entering IDLE via the combo. It is never high for 2 consecutive cycles.
- Timer: 24 bits; it is zero on every state entry and never runs outside DEATH/LEVEL_UP.
- Reset asserted mid-pause: immediate return to the reset values; no pulse is emitted on release.
- o_Flash=0 in all states except DEATH.

Test Plan:
(Bench parameters: DEATH_HOLD=8, LEVELUP_HOLD=4, FLASH_BIT=1.)
1. Release reset, press sw1 → one cycle later o_State=1, o_Reset_Frog high exactly 1 cycle, o_Freeze=0, o_Lives=3, o_Level=1.
2. In PLAY, raise i_Collision and hold → o_Lives=2, o_State=2 for 8 cycles with o_Flash toggling every 2 cycles, then o_State=1 with o_Reset_Frog pulse. The still-high collision does not decrement again.
3. Three collision edges from START_LIVES=3 → lives 2, 1, then o_State=4, o_Lives=0, o_Game_Over=1. Further single-switch edges are ignored; i_Switches=4'hF → o_State=0, o_Lives=3, o_Level=1.
4. Frog-at-top edge 30 times (each followed by the 4-cycle pause) → o_Level counts 2..30 and stays 30 on further edges. Each pause ends with a single o_Reset_Frog pulse.
5. Collision and frog-at-top edges in the same cycle in PLAY → o_State=2, o_Lives decremented, o_Level unchanged.
6. Assert i_Rst_n=0 at timer=5 in DEATH → outputs at reset values immediately. After release, o_Reset_Frog stays 0 until a switch edge.
